tbufcam_mt: RTL

TBUFCAM_MT -- requirements
Module: tbufcam_mt

---
 rtl/tbufcam_mt.sv | 123 ++++++++++++
 1 files changed

// File: rtl/tbufcam_mt.sv
// Multi-thread tag CAM: per-thread partitions with insert, duplicate suppression and per-thread flush.
// Define TBUFCAM_MT_EVICT_EN to replace a victim-pointer entry when an insert hits a full partition.
module tbufcam_mt #(
  parameter int WIDTH   = 11,
  parameter int DEPTH   = 4,
  parameter int THREADS = 2,
  parameter int PORTS   = 2,
  localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   except,
  input  logic [TW-1:0]          except_thread,
  input  logic                   new_en,
  input  logic [WIDTH-1:0]       new_addr,
  input  logic [TW-1:0]          new_thread,
  output logic                   new_ack,
  input  logic [PORTS*WIDTH-1:0] chk_addr,
  input  logic [PORTS*TW-1:0]    chk_thread,
  output logic [PORTS-1:0]       chk_match,
  output logic                   free,
  output logic [OW-1:0]          occ
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q [THREADS];
  logic [WIDTH-1:0] addr_q  [THREADS][DEPTH];
`ifdef TBUFCAM_MT_EVICT_EN
  logic [IW-1:0]    vptr_q  [THREADS];
`endif

  logic          new_ok, exc_ok, exc_same, dup, has_free, req, do_write;
  logic [TW-1:0] nt, et;
  logic [IW-1:0] free_idx, widx;
  logic [OW-1:0] occ_c;

  // Out-of-range thread ids are clamped to 0 for indexing and then masked off.
  always_comb begin
    new_ok   = 32'(new_thread) < THREADS;
    exc_ok   = 32'(except_thread) < THREADS;
    nt       = new_ok ? new_thread : '0;
    et       = exc_ok ? except_thread : '0;
    dup      = 1'b0;
    has_free = 1'b0;
    free_idx = '0;
    occ_c    = '0;
    for (int d = DEPTH - 1; d >= 0; d--) begin
      if (valid_q[nt][d]) begin
        occ_c = occ_c + OW'(1);
        if (addr_q[nt][d] == new_addr) dup = 1'b1;
      end else begin
        has_free = 1'b1;
        free_idx = IW'(d);
      end
    end
    if (!new_ok) begin
      dup      = 1'b0;
      has_free = 1'b0;
      occ_c    = '0;
    end
    exc_same = except && exc_ok && (except_thread == new_thread);
    req      = new_en && !rst && new_ok && !exc_same;
  end

  always_comb begin
`ifdef TBUFCAM_MT_EVICT_EN
    new_ack  = req;
    do_write = req && !dup;
    widx     = has_free ? free_idx : vptr_q[nt];
`else
    new_ack  = req && (dup || has_free);
    do_write = req && !dup && has_free;
    widx     = free_idx;
`endif
    free = has_free;
    occ  = occ_c;
  end

  always_comb begin
    chk_match = '0;
    for (int p = 0; p < PORTS; p++) begin
      logic [TW-1:0]    ct;
      logic [WIDTH-1:0] ca;
      logic             ct_ok;
      ca    = chk_addr[p*WIDTH +: WIDTH];
      ct_ok = 32'(chk_thread[p*TW +: TW]) < THREADS;
      ct    = ct_ok ? chk_thread[p*TW +: TW] : '0;
      for (int d = 0; d < DEPTH; d++) begin
        if (ct_ok && valid_q[ct][d] && addr_q[ct][d] == ca) chk_match[p] = 1'b1;
      end
    end
  end

  // An insert to the flushed thread is already suppressed, so both updates never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < THREADS; t++) begin
        valid_q[t] <= '0;
`ifdef TBUFCAM_MT_EVICT_EN
        vptr_q[t]  <= '0;
`endif
        for (int d = 0; d < DEPTH; d++) addr_q[t][d] <= '0;
      end
    end else begin
      if (except && exc_ok) begin
        valid_q[et] <= '0;
`ifdef TBUFCAM_MT_EVICT_EN
        vptr_q[et]  <= '0;
`endif
      end
      if (do_write) begin
        valid_q[nt][widx] <= 1'b1;
        addr_q[nt][widx]  <= new_addr;
`ifdef TBUFCAM_MT_EVICT_EN
        if (!has_free) vptr_q[nt] <= vptr_q[nt] + IW'(1);
`endif
      end
    end
  end

endmodule
